// File: rtl/hex_display_pkg.sv
// ============================================================================
// hex_display_pkg: active-high 7-segment glyphs (bit order g..a) and decoder
// Rev 1.0
// ============================================================================
`default_nettype none

package hex_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Lowercase b and d keep them distinct from 8 and 0.
  function automatic logic [6:0] seg_of(input logic [3:0] nibble);
    logic [6:0] glyph;
    glyph = SEG_BLANK;
    case (nibble)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = SEG_A;
      4'hB: glyph = SEG_B;
      4'hC: glyph = SEG_C;
      4'hD: glyph = SEG_D;
      4'hE: glyph = SEG_E;
      4'hF: glyph = SEG_F;
    endcase
    return glyph;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hex_seg_decode.sv
// ============================================================================
// hex_seg_decode: combinational nibble to active-high 7-segment glyph
// Rev 1.0
// ============================================================================
`default_nettype none

module hex_seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_of(nibble_i);

endmodule

`default_nettype wire

// File: rtl/hex_display_driver.sv
// ============================================================================
// hex_display_driver: registered multi-digit hex 7-segment driver with
// leading-zero blanking, per-digit blink and a multiplexed scan output
// Rev 1.0
// ============================================================================
`default_nettype none

module hex_display_driver
  import hex_display_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int BLINK_HALF = 12_500_000,
  parameter int SCAN_DIV   = 50_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  lz_en,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [7*DIGITS-1:0]   seg,
  output logic [6:0]            seg_scan,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  valid
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic              C_POL       = (ACTIVE_LOW != 0);
  localparam logic [6:0]        C_SEG_OFF   = {7{C_POL}};
  localparam logic [DIGITS-1:0] C_SEL_OFF   = {DIGITS{C_POL}};
  localparam logic [BW-1:0]     C_BLINK_MAX = BW'(BLINK_HALF - 1);
  localparam logic [SW-1:0]     C_SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     C_IDX_MAX   = IW'(DIGITS - 1);

  logic [4*DIGITS-1:0] value_q;
  logic                lz_q;
  logic [DIGITS-1:0]   mask_q;
  logic                valid_q;

  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [SW-1:0]       scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]       scan_idx_q, scan_idx_d;

  logic [7*DIGITS-1:0] seg_q, seg_d;
  logic [6:0]          seg_scan_q, seg_scan_d;
  logic [DIGITS-1:0]   digit_sel_q, digit_sel_d;

  logic [6:0]          glyph [DIGITS];
  logic [6:0]          digit_seg [DIGITS];
  logic [6:0]          digit_raw;
  logic                upper_zero;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dec
    hex_seg_decode u_dec (
      .nibble_i (value_q[4*i +: 4]),
      .seg_o    (glyph[i])
    );
  end

  // Walk from the top digit down so upper_zero means "this and all higher nibbles are 0".
  always_comb begin
    upper_zero = 1'b1;
    digit_raw  = SEG_BLANK;
    seg_d      = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (value_q[4*i +: 4] == 4'h0);
      if (!valid_q)
        digit_raw = SEG_BLANK;
      else if (lz_q && (i != 0) && upper_zero)
        digit_raw = SEG_BLANK;
      else if (!phase_q && mask_q[i])
        digit_raw = SEG_BLANK;
      else
        digit_raw = glyph[i];
      digit_seg[i]      = digit_raw ^ C_SEG_OFF;
      seg_d[7*i +: 7]   = digit_seg[i];
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (blink_cnt_q == C_BLINK_MAX) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end

    scan_cnt_d = scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == C_SCAN_MAX) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == C_IDX_MAX) ? '0 : scan_idx_q + 1'b1;
    end

    // Select and segments come from the same index so they change together.
    digit_sel_d = (DIGITS'(1) << scan_idx_q) ^ C_SEL_OFF;
    seg_scan_d  = digit_seg[scan_idx_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q     <= '0;
      lz_q        <= 1'b0;
      mask_q      <= '0;
      valid_q     <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      scan_cnt_q  <= '0;
      scan_idx_q  <= '0;
      seg_q       <= {DIGITS{C_SEG_OFF}};
      seg_scan_q  <= C_SEG_OFF;
      digit_sel_q <= C_SEL_OFF;
    end else begin
      if (load) begin
        value_q <= value;
        lz_q    <= lz_en;
        mask_q  <= blink_mask;
        valid_q <= 1'b1;
      end
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      scan_cnt_q  <= scan_cnt_d;
      scan_idx_q  <= scan_idx_d;
      seg_q       <= seg_d;
      seg_scan_q  <= seg_scan_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  assign seg       = seg_q;
  assign seg_scan  = seg_scan_q;
  assign digit_sel = digit_sel_q;
  assign valid     = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_hex_display_driver.sv
// ============================================================================
// tb_hex_display_driver: randomized and directed checks against a cycle model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hex_display_driver;

  localparam int DIGITS     = 4;
  localparam int ACTIVE_LOW = 1;
  localparam int BLINK_HALF = 8;
  localparam int SCAN_DIV   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic [27:0] seg;
  logic [6:0]  seg_scan;
  logic [3:0]  digit_sel;
  logic        valid;

  int n_tests = 0;
  int n_fail  = 0;

  hex_display_driver #(
    .DIGITS     (DIGITS),
    .ACTIVE_LOW (ACTIVE_LOW),
    .BLINK_HALF (BLINK_HALF),
    .SCAN_DIV   (SCAN_DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .value      (value),
    .lz_en      (lz_en),
    .blink_mask (blink_mask),
    .seg        (seg),
    .seg_scan   (seg_scan),
    .digit_sel  (digit_sel),
    .valid      (valid)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: what the design has captured, and cycles counted since reset.
  logic [15:0] m_val;
  logic        m_lz;
  logic [3:0]  m_mask;
  logic        m_valid;
  int          m_cyc;

  logic [27:0] exp_seg;
  logic [6:0]  exp_scan;
  logic [3:0]  exp_sel;
  logic        exp_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] model_digit(input int i);
    logic [6:0] hi;
    bit visible;
    visible = ((m_cyc / BLINK_HALF) % 2) == 0;
    if (!m_valid)
      hi = 7'h00;
    else if (m_lz && i >= 1 && (m_val >> (4 * i)) == 0)
      hi = 7'h00;
    else if (!visible && m_mask[i])
      hi = 7'h00;
    else
      hi = glyph_tab[(m_val >> (4 * i)) & 16'hF];
    return ~hi;
  endfunction

  task automatic step(input logic r, input logic ld, input logic [15:0] v,
                      input logic lz, input logic [3:0] mk);
    int idx;
    reset = r; load = ld; value = v; lz_en = lz; blink_mask = mk;
    @(posedge clk);
    if (r) begin
      exp_seg = {4{7'h7F}}; exp_scan = 7'h7F; exp_sel = 4'hF; exp_valid = 1'b0;
      m_val = '0; m_lz = 1'b0; m_mask = '0; m_valid = 1'b0; m_cyc = 0;
    end else begin
      for (int i = 0; i < DIGITS; i++) exp_seg[7*i +: 7] = model_digit(i);
      idx      = (m_cyc / SCAN_DIV) % DIGITS;
      exp_scan = exp_seg[7*idx +: 7];
      exp_sel  = ~(4'b0001 << idx);
      if (ld) begin
        m_val = v; m_lz = lz; m_mask = mk; m_valid = 1'b1;
      end
      exp_valid = m_valid;
      m_cyc++;
    end
    #1;
    check("seg", 32'(seg), 32'(exp_seg));
    check("seg_scan", 32'(seg_scan), 32'(exp_scan));
    check("digit_sel", 32'(digit_sel), 32'(exp_sel));
    check("valid", 32'(valid), 32'(exp_valid));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
  endtask

  initial begin
    step(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
    check("reset_seg", 32'(seg), 32'({4{7'h7F}}));
    check("reset_sel", 32'(digit_sel), 32'h0000000F);
    idle(3);

    // Value 0 with no blanking: every digit shows 0 two edges after the load.
    step(1'b0, 1'b1, 16'h0000, 1'b0, 4'h0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    check("zero_all", 32'(seg), 32'({4{7'h40}}));

    // Leading-zero blanking of the two top digits.
    step(1'b0, 1'b1, 16'h00B0, 1'b1, 4'h0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    check("lz_00B0", 32'(seg), 32'({7'h7F, 7'h7F, 7'h03, 7'h40}));
    idle(4);

    step(1'b0, 1'b1, 16'h1234, 1'b0, 4'b0001);
    idle(34);

    step(1'b0, 1'b1, 16'hDEAD, 1'b0, 4'h0);
    idle(36);

    // Back-to-back loads: the later value wins.
    step(1'b0, 1'b1, 16'h1111, 1'b0, 4'h0);
    step(1'b0, 1'b1, 16'h2222, 1'b0, 4'h0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    check("b2b_2222", 32'(seg), 32'({4{7'h24}}));
    idle(5);

    // Reset overrides a simultaneous load mid-scan and mid-blink.
    step(1'b0, 1'b1, 16'h8888, 1'b0, 4'b1111);
    idle(9);
    step(1'b1, 1'b1, 16'h5555, 1'b0, 4'b1111);
    check("midreset_valid", 32'(valid), 32'h0);
    check("midreset_sel", 32'(digit_sel), 32'h0000000F);
    step(1'b0, 1'b1, 16'h5555, 1'b0, 4'b1111);
    step(1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
    check("restart_visible", 32'(seg), 32'({4{~7'h6D}}));
    idle(20);

    for (int k = 0; k < 500; k++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 5) == 0),
           16'($urandom), 1'($urandom), 4'($urandom));
    end
    // Sparse values to exercise leading-zero blanking under random timing.
    for (int k = 0; k < 200; k++) begin
      step(1'b0, ($urandom_range(0, 3) == 0), 16'($urandom) >> $urandom_range(0, 16),
           1'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hex_display_driver.md
Name: hex_display_driver

Overview:
- Parametrised multi-digit hexadecimal 7-segment driver for the board HEX displays, successor to the fixed two-digit combinational decoder.
- Captures a DIGITS-nibble value on a load strobe and drives registered per-digit segment outputs.
- Adds leading-zero blanking, per-digit blinking, and a time-multiplexed scan output for boards with shared segment lines.
- Sits between the PS/2 / LCD datapath (value producer) and the board display pins.

Parameters:
- DIGITS, 4: number of hex digits, 1..8.
- ACTIVE_LOW, 1: 1 = segment and digit-select outputs are active-low (board default); 0 = active-high.
- BLINK_HALF, 12_500_000: clock cycles per blink half-period, >= 2.
- SCAN_DIV, 50_000: clock cycles each digit is selected on the scan output, >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load  in  1  capture strobe; sampled on every clk rising edge
- value  in  4*DIGITS  hex value; nibble i drives digit i, digit 0 = least significant
- lz_en  in  1  leading-zero blanking enable, captured with load
- blink_mask  in  DIGITS  per-digit blink enable, captured with load
- seg  out  7*DIGITS  static segments; bits [7i+6:7i] = digit i, bit order g..a
- seg_scan  out  7  multiplexed segments for the currently selected digit
- digit_sel  out  DIGITS  one-hot digit select for seg_scan
- valid  out  1  high once a value has been loaded since reset

Behaviour:
- Reset, synchronous, active-high: value_q=0, lz_q=0, mask_q=0, valid=0, blink counter=0, blink phase=1 (visible), scan counter=0, scan index=0.
- Reset outputs: all seg and seg_scan segments off (7'h7F when ACTIVE_LOW, 7'h00 otherwise); digit_sel all inactive.
- Reset asserted mid-operation overrides load and returns every register to its reset value on the same edge.
- Load:
  - load=1 at edge k captures value, lz_en and blink_mask, and sets valid=1.
  - seg reflects the new data after edge k+1; latency is 2 edges from load sample to pin.
  - Back-to-back loads are legal; the last one wins. There is no backpressure.
- Decode:
  - 0-9 use standard glyphs.
  - A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71 (active-high, bit order g..a). b and d are lowercase so they are distinguishable from 8 and 0.
  - ACTIVE_LOW inverts the final output only.
- Blanking, computed before output registers:
  - valid=0: all digits blank.
  - lz_q=1: digit i (i>=1) is blank when it and every higher nibble are 0. Digit 0 is never LZ-blanked, so value 0 shows a single "0".
  - Blink: a free-running counter counts 0..BLINK_HALF-1, wraps, and toggles the phase on wrap. When phase=0, digits with mask_q[i]=1 are blank.
  - Loading does not reset the blink counter or phase.
  - Precedence: !valid, then LZ blank, then blink blank, then glyph.
- Scan:
  - The scan counter counts 0..SCAN_DIV-1. On wrap, the index increments and wraps from DIGITS-1 to 0.
  - digit_sel is registered one-hot of the index.
  - seg_scan is registered as the static segment value of that digit.
  - Both update on the same edge, so there is no ghosting cycle.
  - DIGITS=1: digit_sel is permanently active after reset release.
- Width rules:
  - Counters are sized as $clog2 of their limit, with a minimum of 1 bit.
  - value is unsigned with no sign extension.

Decomposition:
- Package hex_display_pkg holds:
  - the 16 segment-glyph constants (active-high);
  - SEG_BLANK;
  - a function seg_of(nibble) returning 7 bits.
- Sub-module hex_seg_decode: combinational nibble-to-glyph, instantiated DIGITS times via generate.
- Counters, blanking and scan logic stay in the top module.

Test Plan (DIGITS=4, BLINK_HALF=8, SCAN_DIV=4, ACTIVE_LOW=1):
- Reset, then check segments; load value=16'h0000, lz_en=0 -> after reset, seg all 7'h7F, valid=0; 2 edges after load, every digit = ~7'h3F.
- Load 16'h00B0, lz_en=1 -> digits 3 and 2 blank (7'h7F); digit1 = ~7'h7C; digit0 = ~7'h3F.
- Load 16'h1234, blink_mask=4'b0001 -> digit0 alternates ~7'h66 / 7'h7F every 8 cycles; digits 1-3 are steady.
- Scan with value 16'hDEAD -> digit_sel steps 1110, 1101, 1011, 0111, 1110, 4 cycles each; seg_scan = ~5E, ~77, ~79, ~5E in step order (digits 0-3).
- Load on cycles k and k+1 with 16'h1111 then 16'h2222 -> seg shows 2222 at k+2 and never 1111 at k+2 or later.
- Assert reset mid-scan and mid-blink -> next edge: outputs blank, digit_sel=4'b1111, valid=0; the next load restarts with blink phase visible.
